// File: rtl/cherry_pkg.sv
// Shared lane-packing definitions for the decoder/control unit and the per-class instruction queues.
package cherry_pkg;

    localparam int unsigned MEM_INSTR_WIDTH  = 16;
    localparam int unsigned PROC_INSTR_WIDTH = 16;
    localparam int unsigned APU_INSTR_WIDTH  = 2;
    localparam int unsigned MAX_BURST        = 4;

    // Burst size encoded as n-1: 0 means one instruction, 3 means four.
    typedef logic [1:0] burst_count_t;

    // Decode an encoded burst count into the number of instructions (1..4).
    function automatic logic [2:0] burst_size(input burst_count_t cnt);
        return 3'(cnt) + 3'd1;
    endfunction

endpackage : cherry_pkg

// File: rtl/instruction_queue_if.sv
// Write-burst and read-handshake bundle between the control unit, an instruction queue and its execution unit.
interface instruction_queue_if
    import cherry_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned DEPTH       = 8
) ();

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    logic                             wr_en;
    logic [MAX_BURST*INSTR_WIDTH-1:0] wr_data;
    burst_count_t                     wr_count;
    logic                             wr_ready;
    logic                             rd_valid;
    logic                             rd_ready;
    logic [INSTR_WIDTH-1:0]           rd_data;
    logic [PTR_WIDTH:0]               occupancy;
    logic                             overflow;

    modport master (
        output wr_en, wr_data, wr_count, rd_ready,
        input  wr_ready, rd_valid, rd_data, occupancy, overflow
    );

    modport slave (
        input  wr_en, wr_data, wr_count, rd_ready,
        output wr_ready, rd_valid, rd_data, occupancy, overflow
    );

endinterface : instruction_queue_if

// File: rtl/instruction_queue.sv
// Per-class instruction FIFO: atomic 1-4 lane burst writes, one-per-cycle valid/ready reads.
module instruction_queue
    import cherry_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PTR_WIDTH   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    instruction_queue_if.slave iq
);

    localparam int unsigned OCC_W = PTR_WIDTH + 1;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [OCC_W-1:0]       occ;
    logic                   ovf;

    logic [2:0]             burst_n;
    logic [OCC_W-1:0]       free_slots;
    logic                   wr_accept;
    logic                   pop;

    logic                   lane_we   [MAX_BURST];
    logic [PTR_WIDTH-1:0]   lane_addr [MAX_BURST];
    logic [INSTR_WIDTH-1:0] lane_data [MAX_BURST];

    // Acceptance uses pre-edge occupancy only; a same-cycle pop never makes room.
    assign burst_n    = burst_size(iq.wr_count);
    assign free_slots = OCC_W'(DEPTH) - occ;
    assign wr_accept  = iq.wr_en && (free_slots >= OCC_W'(burst_n));
    assign pop        = (occ != '0) && iq.rd_ready;

    // Per-lane enable and wrapped slot address; lanes beyond the burst are ignored.
    for (genvar i = 0; i < int'(MAX_BURST); i++) begin : g_lane
        assign lane_we[i]   = wr_accept && (3'(i) < burst_n);
        assign lane_addr[i] = wr_ptr + PTR_WIDTH'(i);
        assign lane_data[i] = iq.wr_data[i*INSTR_WIDTH +: INSTR_WIDTH];
    end

    // Storage has no reset; empty-queue reads are masked at the output instead.
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < MAX_BURST; l++) begin
            if (lane_we[l]) begin
                mem[lane_addr[l]] <= lane_data[l];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(burst_n);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            occ <= occ + (wr_accept ? OCC_W'(burst_n) : OCC_W'(0))
                       - (pop ? OCC_W'(1) : OCC_W'(0));
            if (iq.wr_en && !wr_accept) begin
                ovf <= 1'b1;
            end
        end
    end

    assign iq.rd_valid  = (occ != '0);
    assign iq.rd_data   = (occ != '0) ? mem[rd_ptr] : '0;
    assign iq.wr_ready  = (free_slots >= OCC_W'(MAX_BURST));
    assign iq.occupancy = occ;
    assign iq.overflow  = ovf;

endmodule : instruction_queue

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_instruction_queue;
    import cherry_pkg::*;

    localparam int unsigned IW    = 16;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic reset;

    instruction_queue_if #(.INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    instruction_queue #(.INSTR_WIDTH(IW), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .iq    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [IW-1:0] mdl_q [$];
    bit            mdl_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every observable output against the model's current contents.
    task automatic check_outputs(input string tag);
        int sz;
        sz = mdl_q.size();
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'(sz != 0));
        chk({tag, "_rd_data"}, 32'(bus.rd_data), (sz != 0) ? 32'(mdl_q[0]) : 32'd0);
        chk({tag, "_occ"}, 32'(bus.occupancy), 32'(sz));
        chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'((DEPTH - sz) >= 4));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(mdl_ovf));
    endtask

    // One clock: check, drive at negedge, advance model across the posedge.
    task automatic step(input logic we, input logic [1:0] cnt, input logic [63:0] data,
                        input logic rr, input string tag);
        int  n;
        bit  accept;
        bit  do_pop;
        check_outputs(tag);
        bus.wr_en    = we;
        bus.wr_count = cnt;
        bus.wr_data  = data;
        bus.rd_ready = rr;
        n      = int'(cnt) + 1;
        accept = we && ((DEPTH - mdl_q.size()) >= n);
        do_pop = rr && (mdl_q.size() != 0);
        @(posedge clk);
        if (do_pop) void'(mdl_q.pop_front());
        if (accept) begin
            for (int i = 0; i < n; i++) mdl_q.push_back(data[i*16 +: 16]);
        end else if (we) begin
            mdl_ovf = 1'b1;
        end
        @(negedge clk);
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 2'd0, 64'd0, 1'b0, tag);
    endtask

    task automatic pop1(input string tag);
        step(1'b0, 2'd0, 64'd0, 1'b1, tag);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset(input string tag);
        #1 reset = 1'b0;
        #1;
        chk({tag, "_async_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, "_async_occ"}, 32'(bus.occupancy), 32'd0);
        chk({tag, "_async_ovf"}, 32'(bus.overflow), 32'd0);
        chk({tag, "_async_data"}, 32'(bus.rd_data), 32'd0);
        mdl_q.delete();
        mdl_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs({tag, "_post"});
    endtask

    initial begin
        logic [63:0] d;
        reset        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_count = 2'd0;
        bus.wr_data  = 64'd0;
        bus.rd_ready = 1'b0;
        mdl_ovf      = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        chk("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Single instruction in, visible next cycle, then popped.
        step(1'b1, 2'd0, 64'h0000_0000_0000_A001, 1'b0, "t1_wr");
        chk("t1_head", 32'(bus.rd_data), 32'h0000_A001);
        chk("t1_occ1", 32'(bus.occupancy), 32'd1);
        pop1("t1_pop");
        chk("t1_empty", 32'(bus.rd_valid), 32'd0);

        // Four-lane burst drains in lane order.
        step(1'b1, 2'd3, 64'h4444_3333_2222_1111, 1'b0, "t2_wr");
        chk("t2_lane0", 32'(bus.rd_data), 32'h0000_1111);
        repeat (4) pop1("t2_pop");
        chk("t2_empty", 32'(bus.rd_valid), 32'd0);

        // Wrap-around: park pointers at 6, then straddle the end of storage.
        do_reset("t3_rst");
        step(1'b1, 2'd3, 64'h0004_0003_0002_0001, 1'b0, "t3_f4");
        step(1'b1, 2'd1, 64'h0000_0000_0006_0005, 1'b0, "t3_f2");
        repeat (6) pop1("t3_drain");
        step(1'b1, 2'd3, 64'h0008_0007_0006_0005, 1'b0, "t3_wrap");
        chk("t3_peak", 32'(bus.occupancy), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_seq", 32'(bus.rd_data), 32'(i + 5));
            pop1("t3_pop");
        end

        // Rejected burst at occupancy 6, then an exact fill.
        do_reset("t4_rst");
        step(1'b1, 2'd3, 64'h00A4_00A3_00A2_00A1, 1'b0, "t4_f4");
        step(1'b1, 2'd1, 64'h0000_0000_00A6_00A5, 1'b0, "t4_f2");
        step(1'b1, 2'd2, 64'h0000_00B3_00B2_00B1, 1'b0, "t4_rej");
        chk("t4_rej_occ", 32'(bus.occupancy), 32'd6);
        chk("t4_rej_ovf", 32'(bus.overflow), 32'd1);
        step(1'b1, 2'd1, 64'h0000_0000_00C2_00C1, 1'b0, "t4_fill");
        chk("t4_full_occ", 32'(bus.occupancy), 32'd8);
        chk("t4_full_wrdy", 32'(bus.wr_ready), 32'd0);
        // Full: write rejected but the pop still happens.
        step(1'b1, 2'd0, 64'h0000_0000_0000_00D1, 1'b1, "t4_fullpop");
        chk("t4_fullpop_occ", 32'(bus.occupancy), 32'd7);

        // Simultaneous write and pop; a pop does not free room for the same-cycle write.
        do_reset("t5_rst");
        step(1'b1, 2'd3, 64'h0014_0013_0012_0011, 1'b0, "t5_f4");
        step(1'b1, 2'd0, 64'h0000_0000_0000_0015, 1'b0, "t5_f1");
        step(1'b1, 2'd2, 64'h0000_0018_0017_0016, 1'b1, "t5_wp");
        chk("t5_occ7", 32'(bus.occupancy), 32'd7);
        step(1'b1, 2'd1, 64'h0000_0000_001A_0019, 1'b1, "t5_rejpop");
        chk("t5_occ6", 32'(bus.occupancy), 32'd6);
        chk("t5_ovf", 32'(bus.overflow), 32'd1);

        // Mid-stream async reset with occupancy 5 and overflow set.
        do_reset("t6_pre");
        step(1'b1, 2'd3, 64'h0024_0023_0022_0021, 1'b0, "t6_f4");
        step(1'b1, 2'd0, 64'h0000_0000_0000_0025, 1'b0, "t6_f1");
        step(1'b1, 2'd3, 64'h0029_0028_0027_0026, 1'b1, "t6_rej");
        step(1'b1, 2'd0, 64'h0000_0000_0000_002A, 1'b0, "t6_refill");
        chk("t6_occ5", 32'(bus.occupancy), 32'd5);
        do_reset("t6_rst");
        chk("t6_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Random traffic against the model, with occasional resets.
        for (int c = 0; c < 400; c++) begin
            d = {$urandom(), $urandom()};
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d,
                 1'($urandom_range(0, 9) < 6), "rnd");
        end
        check_outputs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_instruction_queue
